// File: rtl/cheat_pkg.sv
// Constants and types shared by the cheat loader and the cheat engine:
// the 129-bit code word layout, flag bit indices and the loader state encoding.
package cheat_pkg;

   localparam int REPLACE_LSB = 0;
   localparam int COMPARE_LSB = 32;
   localparam int ADDR_LSB    = 64;
   localparam int FLAGS_LSB   = 96;
   localparam int STROBE_BIT  = 128;
   localparam int CODE_W      = 129;

   localparam int COMP_F  = 0;
   localparam int WIDTH_F = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_COLLECT,
      S_STROBE_HI,
      S_STROBE_LO
   } state_t;

   // File byte index within a record -> LSB of that byte in the big-endian payload.
   function automatic int byte_lsb(input logic [3:0] idx);
      return FLAGS_LSB - 32 * int'(idx[3:2]) + 8 * int'(idx[1:0]);
   endfunction

endpackage

// File: rtl/cheat_loader_if.sv
// ioctl download channel as seen between the file source (master) and the
// cheat loader (slave).
interface cheat_loader_if #(
   parameter int DW = 16
);

   logic          ioctl_download;
   logic          ioctl_wr;
   logic [DW-1:0] ioctl_dout;
   logic          ioctl_wait;

   modport master (output ioctl_download, ioctl_wr, ioctl_dout, input ioctl_wait);
   modport slave  (input  ioctl_download, ioctl_wr, ioctl_dout, output ioctl_wait);

endinterface

// File: rtl/cheat_byte_asm.sv
// Byte counter plus 128-bit record assembly; places little-endian file bytes
// into big-endian fields and flags the write that completes a record.
module cheat_byte_asm
   import cheat_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [DW-1:0] din,
   output logic [127:0]  record,
   output logic          record_done
);

   localparam int         BPW       = DW / 8;
   localparam logic [3:0] LAST_BCNT = 4'(16 - BPW);

   logic [3:0]   bcnt;
   logic [127:0] asm_q;

   // The completing write is merged combinationally so the whole record is
   // available in the same cycle record_done is raised.
   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      record = asm_q;
      if (wr_en) begin
         for (int k = 0; k < BPW; k++) begin
            record[byte_lsb(bcnt + 4'(k)) +: 8] = din[8*k +: 8];
         end
      end
   end

   assign record_done = wr_en && (bcnt == LAST_BCNT);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         bcnt  <= '0;
         asm_q <= '0;
      end else if (wr_en) begin
         bcnt  <= bcnt + 4'(BPW);
         asm_q <= record;
      end
   end

endmodule

// File: rtl/cheat_loader.sv
// Cheat file loader: collects 16-byte records from the ioctl stream and emits
// each as a 129-bit code word with a clean strobe edge on bit 128.
module cheat_loader
   import cheat_pkg::*;
#(
   parameter int DW            = 16,
   parameter int MAX_CODES     = 32,
   parameter int STROBE_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   cheat_loader_if.slave                  io,
   output logic                           codes_reset,
   output logic [CODE_W-1:0]              code,
   output logic [$clog2(MAX_CODES+1)-1:0] code_count,
   output logic                           overflow
);

   localparam int            CW          = $clog2(MAX_CODES + 1);
   localparam int            SW          = $clog2(STROBE_CYCLES + 1);
   localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] MAX_COUNT   = CW'(MAX_CODES);

   state_t        state;
   logic          dl_prev;
   logic          wait_q;
   logic [SW-1:0] scnt;
   logic          wr_en;
   logic          record_done;
   logic [127:0]  record;

   // Writes outside COLLECT arrive while ioctl_wait is high and are dropped.
   assign wr_en       = io.ioctl_wr && io.ioctl_download && (state == S_COLLECT);
   assign io.ioctl_wait = wait_q;

   cheat_byte_asm #(.DW(DW)) u_asm (
      .clk         (clk),
      .reset       (reset),
      .clear       (state == S_CLEAR),
      .wr_en       (wr_en),
      .din         (io.ioctl_dout),
      .record      (record),
      .record_done (record_done)
   );

   // NOTE: every state register uses <= so each branch reads pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         dl_prev     <= 1'b0;
         wait_q      <= 1'b0;
         scnt        <= '0;
         codes_reset <= 1'b0;
         code        <= '0;
         code_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         dl_prev     <= io.ioctl_download;
         codes_reset <= 1'b0;
         case (state)
            S_IDLE: begin
               if (io.ioctl_download && !dl_prev) begin
                  state       <= S_CLEAR;
                  codes_reset <= 1'b1;
                  wait_q      <= 1'b1;
                  code_count  <= '0;
                  overflow    <= 1'b0;
               end
            end
            S_CLEAR: begin
               state  <= S_COLLECT;
               wait_q <= 1'b0;
            end
            S_COLLECT: begin
               // A dropped download abandons any partial record.
               if (!io.ioctl_download) begin
                  state <= S_IDLE;
               end else if (record_done) begin
                  if (code_count < MAX_COUNT) begin
                     state  <= S_STROBE_HI;
                     code   <= {1'b1, record};
                     wait_q <= 1'b1;
                     scnt   <= '0;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            S_STROBE_HI: begin
               if (scnt == STROBE_LAST) begin
                  state            <= S_STROBE_LO;
                  code[STROBE_BIT] <= 1'b0;
                  scnt             <= '0;
               end else begin
                  scnt <= scnt + SW'(1);
               end
            end
            S_STROBE_LO: begin
               if (scnt == STROBE_LAST) begin
                  if (code_count != MAX_COUNT) code_count <= code_count + CW'(1);
                  wait_q <= 1'b0;
                  state  <= io.ioctl_download ? S_COLLECT : S_IDLE;
               end else begin
                  scnt <= scnt + SW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cheat_loader.sv
// Directed bench for cheat_loader: an 8-bit instance limited to two codes and
// a 16-bit instance, with expected code words queued as records are sent.
module tb_cheat_loader;
   import cheat_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cheat_loader_if #(.DW(8))  io8 ();
   cheat_loader_if #(.DW(16)) io16 ();

   logic [128:0] code8, code16;
   logic         cr8, cr16, ov8, ov16;
   logic [1:0]   cnt8;
   logic [5:0]   cnt16;

   cheat_loader #(.DW(8), .MAX_CODES(2), .STROBE_CYCLES(4)) u8 (
      .clk(clk), .reset(reset), .io(io8), .codes_reset(cr8),
      .code(code8), .code_count(cnt8), .overflow(ov8));

   cheat_loader #(.DW(16), .MAX_CODES(32), .STROBE_CYCLES(4)) u16 (
      .clk(clk), .reset(reset), .io(io16), .codes_reset(cr16),
      .code(code16), .code_count(cnt16), .overflow(ov16));

   int           vectors = 0;
   int           errors  = 0;
   logic [127:0] sb[$];
   logic [127:0] last_exp;
   logic [7:0]   rec[16];
   localparam logic [127:0] PLAN_CODE = {32'h1, 32'h1234, 32'hAA, 32'h55};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [128:0] obs);
      if (sb.size() == 0) begin
         vectors++;
         errors++;
         $error("FAIL %s: observed %0h expected queued code (queue empty)", tag, obs);
      end else begin
         last_exp = sb.pop_front();
         check(tag, obs, {1'b1, last_exp});
      end
   endtask

   task automatic set_plan_rec();
      logic [7:0] p[16] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00,
                            8'hAA, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 16; i++) rec[i] = p[i];
   endtask

   task automatic set_model_rec(input logic [7:0] seed);
      for (int i = 0; i < 16; i++) rec[i] = 8'(i * 29) ^ seed;
   endtask

   function automatic logic [127:0] model_code();
      logic [127:0] m;
      for (int f = 0; f < 4; f++)
         m[127 - 32*f -: 32] = {rec[4*f+3], rec[4*f+2], rec[4*f+1], rec[4*f]};
      return m;
   endfunction

   task automatic send8(input int nbytes, input bit push, input logic [127:0] exp);
      if (push) sb.push_back(exp);
      for (int i = 0; i < nbytes; i++) begin
         io8.ioctl_wr   = 1'b1;
         io8.ioctl_dout = rec[i];
         tick();
      end
      io8.ioctl_wr = 1'b0;
   endtask

   task automatic send16(input logic [127:0] exp);
      sb.push_back(exp);
      for (int i = 0; i < 8; i++) begin
         io16.ioctl_wr   = 1'b1;
         io16.ioctl_dout = {rec[2*i+1], rec[2*i]};
         tick();
      end
      io16.ioctl_wr = 1'b0;
   endtask

   task automatic measure8(output int hi, output int lo);
      hi = 0;
      while (code8[STROBE_BIT] && hi < 50) begin hi++; tick(); end
      lo = 0;
      while (!code8[STROBE_BIT] && io8.ioctl_wait && lo < 50) begin lo++; tick(); end
   endtask

   initial begin
      int hi, lo, n;
      reset = 1'b1;
      io8.ioctl_download  = 1'b0; io8.ioctl_wr  = 1'b0; io8.ioctl_dout  = '0;
      io16.ioctl_download = 1'b0; io16.ioctl_wr = 1'b0; io16.ioctl_dout = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_code8",  code8, '0);
      check("rst_wait8",  129'(io8.ioctl_wait), '0);
      check("rst_cr8",    129'(cr8), '0);
      check("rst_cnt8",   129'(cnt8), '0);
      check("rst_ov8",    129'(ov8), '0);
      check("rst_state8", 129'(u8.state), 129'(S_IDLE));
      check("rst_code16", code16, '0);

      // 16-bit channel: one record as eight words
      io16.ioctl_download = 1'b1;
      tick();
      check("cr16_pulse", 129'(cr16), 129'(1));
      tick();
      check("cr16_low", 129'(cr16), '0);
      set_plan_rec();
      send16(PLAN_CODE);
      pop_check("code16", code16);
      n = 0;
      while (io16.ioctl_wait && n < 50) begin n++; tick(); end
      check("wait16_len",   129'(n), 129'(8));
      check("cnt16",        129'(cnt16), 129'(1));
      check("state16_coll", 129'(u16.state), 129'(S_COLLECT));
      io16.ioctl_download = 1'b0;
      tick();

      // 8-bit channel: three records against MAX_CODES=2
      io8.ioctl_download = 1'b1;
      tick();
      check("cr8_pulse", 129'(cr8), 129'(1));
      tick();
      check("cr8_low", 129'(cr8), '0);
      set_plan_rec();
      send8(16, 1'b1, PLAN_CODE);
      pop_check("code8_r1", code8);
      measure8(hi, lo);
      check("hi8_r1",  129'(hi), 129'(4));
      check("lo8_r1",  129'(lo), 129'(4));
      check("cnt8_r1", 129'(cnt8), 129'(1));
      set_model_rec(8'h3C);
      send8(16, 1'b1, model_code());
      pop_check("code8_r2", code8);
      measure8(hi, lo);
      check("hi8_r2",  129'(hi), 129'(4));
      check("lo8_r2",  129'(lo), 129'(4));
      check("cnt8_r2", 129'(cnt8), 129'(2));
      set_model_rec(8'h77);
      send8(16, 1'b0, '0);
      check("ovf_hold", code8, {1'b0, last_exp});
      check("ovf_wait", 129'(io8.ioctl_wait), '0);
      check("ovf_flag", 129'(ov8), 129'(1));
      check("ovf_cnt",  129'(cnt8), 129'(2));
      io8.ioctl_download = 1'b0;
      tick(); tick();
      check("end_state8", 129'(u8.state), 129'(S_IDLE));
      check("end_ov8",    129'(ov8), 129'(1));

      // second download clears count and overflow; then a partial record
      io8.ioctl_download = 1'b1;
      tick();
      check("cr8_pulse2", 129'(cr8), 129'(1));
      tick();
      check("cr8_low2", 129'(cr8), '0);
      check("cnt8_clr", 129'(cnt8), '0);
      check("ov8_clr",  129'(ov8), '0);
      set_plan_rec();
      send8(10, 1'b0, '0);
      check("part_wait", 129'(io8.ioctl_wait), '0);
      io8.ioctl_download = 1'b0;
      tick(); tick();
      check("part_state",  129'(u8.state), 129'(S_IDLE));
      check("part_strobe", 129'(code8[STROBE_BIT]), '0);
      check("part_cnt",    129'(cnt8), '0);

      // third download: fresh record, then reset during STROBE_HI
      io8.ioctl_download = 1'b1;
      tick(); tick();
      set_model_rec(8'hA5);
      send8(16, 1'b1, model_code());
      pop_check("code8_r3", code8);
      tick();
      check("r3_still_hi", 129'(code8[STROBE_BIT]), 129'(1));
      reset = 1'b1;
      tick();
      check("mid_rst_code",  code8, '0);
      check("mid_rst_wait",  129'(io8.ioctl_wait), '0);
      check("mid_rst_state", 129'(u8.state), 129'(S_IDLE));
      reset = 1'b0;
      io8.ioctl_download = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
